vga_sync_decoder: RTL and testbench

//   Receive-side counterpart of the VGA sync generator. Samples hsync/vsync,

---
 rtl/vga_sync_decoder.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing recovery. Samples hsync/vsync, rebuilds the
//   horizontal/vertical counters, produces pixel coordinates and an
//   active-video flag, and declares lock once the measured line and frame
//   lengths match the configured mode for LOCK_FRAMES consecutive frames.
//
// Ports
//   clock        in   pixel clock, syncs are synchronous to it
//   reset        in   asynchronous, active-low reset
//   hsync_in     in   horizontal sync (polarity set by SYNC_POL)
//   vsync_in     in   vertical sync (polarity set by SYNC_POL)
//   x, y         out  active pixel column / line, 0 outside active video
//   active       out  locked and inside the active window
//   line_start   out  one-cycle pulse at the start of every line
//   frame_start  out  one-cycle pulse at the start of every frame
//   locked       out  lock FSM is in LOCKED
//   sync_err     out  one-cycle pulse when lock is lost
//   h_meas       out  last measured line length   (VGA_SYNC_DECODER_MEASURE_EN)
//   v_meas       out  last measured frame length  (VGA_SYNC_DECODER_MEASURE_EN)
//
// Optional feature: define VGA_SYNC_DECODER_MEASURE_EN to add h_meas/v_meas.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480,
  parameter int SYNC_POL    = 0,
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 11
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          locked,
  output logic          sync_err
`ifdef VGA_SYNC_DECODER_MEASURE_EN
  ,
  output logic [CW-1:0] h_meas,
  output logic [CW-1:0] v_meas
`endif
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] H_START_C = CW'(H_START);
  localparam logic [CW-1:0] H_END_C   = CW'(H_START + H_ACTIVE);
  localparam logic [CW-1:0] V_START_C = CW'(V_START);
  localparam logic [CW-1:0] V_END_C   = CW'(V_START + V_ACTIVE);
  // Two missing line periods without an hsync edge means the source is gone.
  localparam logic [CW-1:0] TIMEOUT_C = CW'(2 * H_TOTAL);
  localparam logic [3:0]    LOCK_C    = 4'(LOCK_FRAMES);
  // XOR mask that turns the incoming polarity into 1 = asserted.
  localparam logic          POL_INV   = (SYNC_POL == 0);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    good;

  logic          hs_q, hs_q_d, vs_q, vs_q_d;
  logic          hs_edge, vs_edge, hs_edge_d;
  logic [CW-1:0] hcnt, vcnt;
  logic [CW-1:0] line_len, frame_len;
  logic          vs_pend, bad_line;
  logic          line_bad, boundary, frame_ok, timeout, in_win;

  always_comb begin
    hs_edge   = hs_q & ~hs_q_d;
    vs_edge   = vs_q & ~vs_q_d;
    // Saturating +1 so a stuck counter never wraps into a plausible length.
    line_len  = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + ONE;
    frame_len = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + ONE;
    line_bad  = hs_edge && (line_len != H_TOTAL_C);
    // A vsync edge may arrive with the hsync edge or some clocks ahead of it;
    // either way the frame boundary is taken on the hsync edge.
    boundary  = hs_edge && (vs_pend || vs_edge);
    // The line ending at the boundary belongs to the frame being judged.
    frame_ok  = !bad_line && !line_bad && (frame_len == V_TOTAL_C);
    timeout   = (hcnt == TIMEOUT_C);
    in_win    = locked &&
                (hcnt >= H_START_C) && (hcnt < H_END_C) &&
                (vcnt >= V_START_C) && (vcnt < V_END_C);
  end

  // Sync input registers, polarity-normalised.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q      <= 1'b0;
      hs_q_d    <= 1'b0;
      vs_q      <= 1'b0;
      vs_q_d    <= 1'b0;
      hs_edge_d <= 1'b0;
    end else begin
      hs_q      <= hsync_in ^ POL_INV;
      hs_q_d    <= hs_q;
      vs_q      <= vsync_in ^ POL_INV;
      vs_q_d    <= vs_q;
      hs_edge_d <= hs_edge;
    end
  end

  // Line/frame counters and per-frame line-length bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt     <= '0;
      vcnt     <= '0;
      vs_pend  <= 1'b0;
      bad_line <= 1'b0;
    end else begin
      if (hs_edge) begin
        hcnt <= '0;
      end else if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + ONE;
      end

      if (hs_edge) begin
        if (vs_pend || vs_edge) begin
          vcnt <= '0;
        end else if (vcnt != CNT_MAX) begin
          vcnt <= vcnt + ONE;
        end
      end

      if (boundary) begin
        vs_pend <= 1'b0;
      end else if (vs_edge) begin
        vs_pend <= 1'b1;
      end

      if (boundary) begin
        bad_line <= 1'b0;
      end else if (line_bad) begin
        bad_line <= 1'b1;
      end
    end
  end

  // Lock FSM. The first boundary seen from SEARCH only aligns us; that
  // partial frame is never counted as good.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      good     <= 4'd0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        SEARCH: begin
          good <= 4'd0;
          if (boundary) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (timeout) begin
            state <= SEARCH;
            good  <= 4'd0;
          end else if (boundary) begin
            if (frame_ok) begin
              good <= good + 4'd1;
              if (good + 4'd1 == LOCK_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good <= 4'd0;
            end
          end
        end
        LOCKED: begin
          if (timeout || line_bad || (boundary && !frame_ok)) begin
            state    <= SEARCH;
            good     <= 4'd0;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          good   <= 4'd0;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // hs_edge_d marks the cycle in which hcnt holds its fresh 0.
      line_start  <= hs_edge_d;
      frame_start <= hs_edge_d && (vcnt == '0);
      active      <= in_win;
      x           <= in_win ? hcnt - H_START_C : '0;
      y           <= in_win ? vcnt - V_START_C : '0;
    end
  end

`ifdef VGA_SYNC_DECODER_MEASURE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_meas <= '0;
      v_meas <= '0;
    end else begin
      if (hs_edge) begin
        h_meas <= line_len;
      end
      if (boundary) begin
        v_meas <= frame_len;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Directed bench for vga_sync_decoder using a shrunken video mode so whole
//   frames fit in a short run. A second instance with SYNC_POL=1 is fed the
//   inverted stream. Timing expectations are hand-derived from the pipeline:
//   sync drive -> hs_q (edge 1) -> counters (edge 2) -> outputs (edge 3).
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HS  = 8;
  localparam int HA  = 24;
  localparam int VT  = 20;
  localparam int VS  = 4;
  localparam int VA  = 12;
  localparam int HSW = 4;
  localparam int VSW = 2;
  localparam int CW  = 11;
  localparam int LF  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          hsync = 1'b1;
  logic          vsync = 1'b1;
  logic          hsync_p, vsync_p;
  logic [CW-1:0] x, y, x_p, y_p;
  logic          active, line_start, frame_start, locked, sync_err;
  logic          active_p, line_start_p, frame_start_p, locked_p, sync_err_p;
`ifdef VGA_SYNC_DECODER_MEASURE_EN
  logic [CW-1:0] h_meas, v_meas, h_meas_p, v_meas_p;
`endif

  assign hsync_p = ~hsync;
  assign vsync_p = ~vsync;

  always #5 clock = ~clock;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA),
    .SYNC_POL(0), .LOCK_FRAMES(LF), .CW(CW)
  ) dut (
    .clock(clock), .reset(reset), .hsync_in(hsync), .vsync_in(vsync),
    .x(x), .y(y), .active(active), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
`ifdef VGA_SYNC_DECODER_MEASURE_EN
    , .h_meas(h_meas), .v_meas(v_meas)
`endif
  );

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA),
    .SYNC_POL(1), .LOCK_FRAMES(LF), .CW(CW)
  ) dut_p (
    .clock(clock), .reset(reset), .hsync_in(hsync_p), .vsync_in(vsync_p),
    .x(x_p), .y(y_p), .active(active_p), .line_start(line_start_p),
    .frame_start(frame_start_p), .locked(locked_p), .sync_err(sync_err_p)
`ifdef VGA_SYNC_DECODER_MEASURE_EN
    , .h_meas(h_meas_p), .v_meas(v_meas_p)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: cumulative counters and per-frame first/last active pixel.
  int  act_cnt = 0, act_cnt_p = 0, ls_cnt = 0, fs_cnt = 0, err_cnt = 0, err_cnt_p = 0;
  bit  fr_seen = 1'b0;
  int  first_x = 0, first_y = 0, last_x = 0, last_y = 0;
  time t_first = 0, t_fs = 0, t_err = 0, t_lock = 0;
  bit  err_locked = 1'b0, locked_d = 1'b0;

  always @(posedge clock) begin
    #1;
    if (frame_start) begin
      fs_cnt++;
      t_fs    = $time;
      fr_seen = 1'b0;
    end
    if (active) begin
      if (!fr_seen) begin
        fr_seen = 1'b1;
        first_x = int'(x);
        first_y = int'(y);
        t_first = $time;
      end
      last_x = int'(x);
      last_y = int'(y);
      act_cnt++;
    end
    if (active_p)   act_cnt_p++;
    if (line_start) ls_cnt++;
    if (sync_err) begin
      err_cnt++;
      t_err      = $time;
      err_locked = locked;
    end
    if (sync_err_p) err_cnt_p++;
    if (locked && !locked_d) t_lock = $time;
    locked_d = locked;
  end

  // Stream generator (reference polarity active-low). t_line holds the drive
  // time of each line's hsync leading edge in the most recent frame.
  time t_line [VT];

  task automatic send_frame(input int long_line, input bit early_vs);
    int  len;
    bit  hs_a, vs_a;
    for (int l = 0; l < VT; l++) begin
      len = (l == long_line) ? HT + 1 : HT;
      for (int p = 0; p < len; p++) begin
        @(negedge clock);
        if (p == 0) t_line[l] = $time;
        hs_a  = (p < HSW);
        vs_a  = (l < VSW) || (early_vs && (l == VT - 1) && (p >= len - 10));
        hsync = ~hs_a;
        vsync = ~vs_a;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      hsync = 1'b1;
      vsync = 1'b1;
    end
  endtask

  int a0, ap0, l0, f0, e0, ep0;

  initial begin
    // Reset held with syncs toggling: every output stays 0.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      hsync = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      #1;
      chk("rst_out", {x, y, active, line_start, frame_start, locked, sync_err}, 0);
    end
    @(negedge clock);
    hsync = 1'b1;
    vsync = 1'b1;
    reset = 1'b1;
    idle(5);

    // Initial lock: one aligning frame, two good frames, lock at 3rd boundary.
    send_frame(-1, 1'b0);
    send_frame(-1, 1'b0);
    chk("lock_not_yet", locked, 0);
    a0 = act_cnt; ap0 = act_cnt_p; l0 = ls_cnt; f0 = fs_cnt;
    send_frame(-1, 1'b0);
    chk("lock_time", t_lock - t_line[0], 16);
    chk("locked", locked, 1);
    chk("locked_pol1", locked_p, 1);
    chk("active_cnt", act_cnt - a0, HA * VA);
    chk("active_cnt_pol1", act_cnt_p - ap0, HA * VA);
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("first_lat", t_first - t_line[VS], (HS + 3) * 10 - 4);
    chk("last_x", last_x, HA - 1);
    chk("last_y", last_y, VA - 1);
    chk("line_starts", ls_cnt - l0, VT);
    chk("frame_starts", fs_cnt - f0, 1);
    chk("fs_lat", t_fs - t_line[0], 26);
`ifdef VGA_SYNC_DECODER_MEASURE_EN
    chk("h_meas", h_meas, HT);
    chk("v_meas", v_meas, VT);
`endif

    // One 801-style long line while locked.
    e0 = err_cnt; ep0 = err_cnt_p;
    send_frame(10, 1'b0);
    chk("long_err", err_cnt - e0, 1);
    chk("long_err_pol1", err_cnt_p - ep0, 1);
    chk("long_err_locked", err_locked, 0);
    chk("long_unlocked", locked, 0);
    send_frame(-1, 1'b0);
    send_frame(-1, 1'b0);
    chk("relock_not_yet", locked, 0);
    send_frame(-1, 1'b0);
    chk("relock", locked, 1);
    chk("relock_time", t_lock - t_line[0], 16);

    // vsync 10 clocks ahead of the hsync edge must give the same boundary.
    e0 = err_cnt;
    send_frame(-1, 1'b1);
    a0 = act_cnt; f0 = fs_cnt;
    send_frame(-1, 1'b0);
    chk("early_fs_lat", t_fs - t_line[0], 26);
    chk("early_fs_cnt", fs_cnt - f0, 1);
    chk("early_first_y", first_y, 0);
    chk("early_active_cnt", act_cnt - a0, HA * VA);
    chk("early_locked", locked, 1);
    chk("early_no_err", err_cnt - e0, 0);

    // Syncs stop: loss of signal after two line periods.
    e0 = err_cnt;
    idle(100);
    chk("lost_err", err_cnt - e0, 1);
    chk("lost_time", t_err - t_line[VT - 1], (2 * HT + 3) * 10 - 4);
    chk("lost_unlocked", locked, 0);
    chk("lost_unlocked_pol1", locked_p, 0);
    idle(100);
    chk("lost_single_err", err_cnt - e0, 1);

    // Timeout while in CHECK: back to SEARCH quietly, then normal relock.
    e0 = err_cnt;
    send_frame(-1, 1'b0);
    idle(100);
    chk("check_timeout_no_err", err_cnt - e0, 0);
    send_frame(-1, 1'b0);
    send_frame(-1, 1'b0);
    chk("relock2_not_yet", locked, 0);
    send_frame(-1, 1'b0);
    chk("relock2", locked, 1);

    // Asynchronous reset in the middle of an active line.
    fork
      send_frame(-1, 1'b0);
      begin
        repeat (HT * 7 + 16) @(negedge clock);
        #3;
        chk("pre_rst_active", active, 1);
        chk("pre_rst_x", x, 4);
        chk("pre_rst_y", y, 3);
        reset = 1'b0;
        #1;
        chk("async_rst_out", {x, y, active, line_start, frame_start, locked, sync_err}, 0);
        #19;
        reset = 1'b1;
      end
    join
    chk("post_rst_unlocked", locked, 0);
    send_frame(-1, 1'b0);
    send_frame(-1, 1'b0);
    chk("post_rst_not_yet", locked, 0);
    send_frame(-1, 1'b0);
    chk("post_rst_relock", locked, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
